cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 pipeline. Holds SR, Cause and EPC.
- Collects the exception code and the BD flag from the M stage, together with the six hardware interrupt lines.
- Raises the exception/interrupt request consumed by next-PC selection.
- Supplies the stored EPC for eret return.
- Sits at the M stage; mfc0/mtc0 and eret are serviced there.

Parameters:
- SR_ADDR, 5'd12, CP0 register number of SR.
- CAUSE_ADDR, 5'd13, CP0 register number of Cause.
- EPC_ADDR, 5'd14, CP0 register number of EPC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- En  input  1  mtc0 write enable (M-stage mtc0).
- CP0Add  input  5  CP0 register number for mfc0/mtc0.
- CP0In  input  32  mtc0 write data.
- CP0Out  output  32  mfc0 read data; combinational.
- VPC  input  32  PC of the M-stage instruction.
- BDIn  input  1  M-stage instruction sits in a branch/jump delay slot.
- ExcCodeIn  input  5  M-stage exception code; 0 means no exception.
- HWInt  input  6  external interrupt lines, level-sensitive.
- EXLClr  input  1  eret in M stage.
- Req  output  1  take exception/interrupt this cycle; combinational.
- EPCOut  output  32  current EPC register value.

Behaviour:
- Field layout:
  - SR: IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause: BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC: full 32 bits, but bits [1:0] are forced to 0 on every write.
- Reset (synchronous, active-high): SR, Cause and EPC all go to 0. With EXL = 0, IE = 0 and ExcCodeIn = 0, Req is 0.
- Request logic (combinational, same cycle):
  - IntReq = IE & ~EXL & |(HWInt & IM)
  - ExcReq = (ExcCodeIn != 0) & ~EXL
  - Req = IntReq | ExcReq
- Priority: interrupt over exception. When both are asserted, ExcCode is recorded as 0 (Int).
- Clock edge with Req = 1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 5'd0 : ExcCodeIn.
  - EPC <= BDIn ? VPC - 4 : VPC, with [1:0] forced 0.
  - Any mtc0 write in the same cycle is discarded. The victim instruction does not commit.
  - A simultaneous EXLClr is ignored: EXL ends at 1.
- Clock edge with Req = 0:
  - EXLClr = 1 sets EXL <= 0.
  - If En = 1:
    - CP0Add = SR_ADDR writes IM, EXL and IE from CP0In.
    - CP0Add = EPC_ADDR writes EPC.
    - CP0Add = CAUSE_ADDR, and any other address, is ignored. Cause is read-only to software.
  - If mtc0 SR and EXLClr occur in the same cycle, the mtc0 value is written first and then EXL is cleared.
- IP tracking: Cause.IP <= HWInt on every non-reset edge, independent of Req and En.
- Read path: CP0Out returns the SR, Cause or EPC view per the layouts above, and 0 for any other address. It reflects register state before the current edge; there is no write-through bypass.
- EPCOut: equals the EPC register. The consumer forms the return PC.
- mtc0 EPC followed by eret: the hazard unit stalls eret until the mtc0 has left M. This block provides no bypass.
- Nested requests: while EXL = 1, neither interrupts nor exceptions assert Req. HWInt still updates IP.
- Arithmetic: VPC - 4 is 32-bit modular. VPC = 0 with BDIn = 1 yields 32'hFFFF_FFFC.

Decomposition:
- Shared package (cp0_defs): SR/Cause/EPC address constants, the IM/EXL/IE/BD/IP/ExcCode bit positions, and the ExcCode enumeration (Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12).
- One natural sub-module: cp0_req_gen, the combinational IntReq/ExcReq/Req and ExcCode selection. It is reusable by the hazard unit for flush decisions.
- Registers stay in cp0_unit.

Test Plan:
1. Reset, then mfc0 of addresses 12/13/14 -> CP0Out = 0 for all three; Req = 0 with HWInt = 6'b111111.
2. mtc0 SR = 32'h0000_FC01, then HWInt[2] = 1, VPC = 32'h0000_3010, BDIn = 0:
   - Req = 1 that cycle.
   - Next edge: EPC = 32'h3010, ExcCode = 0, EXL = 1, Cause = 32'h0000_1000.
3. IE = 0; ExcCodeIn = 10 (RI), VPC = 32'h3024, BDIn = 1:
   - Req = 1.
   - EPC = 32'h3020, Cause[31] = 1, ExcCode = 10.
4. With EXL = 1, ExcCodeIn = 12 and HWInt = 6'b000001 -> Req = 0; IP tracks HWInt. Then EXLClr = 1 -> EXL = 0, and Req rises next cycle.
5. Same cycle: ExcCodeIn = 4, En = 1, CP0Add = 14, CP0In = 32'h1234 -> EPC = VPC (mtc0 discarded), ExcCode = 4.
6. mtc0 Cause = 32'hFFFF_FFFF -> Cause unchanged. mtc0 EPC = 32'h0000_3007 -> EPCOut = 32'h0000_3004.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// cp0_defs: shared CP0 constants for the P7 pipeline.
// Holds the register numbers, the SR/Cause field positions and the
// exception code enumeration. cp0_unit, cp0_req_gen and the hazard unit use it.
package cp0_defs;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned EXC_W  = 5;

    localparam logic [ADDR_W-1:0] SR_ADDR    = 5'd12;
    localparam logic [ADDR_W-1:0] CAUSE_ADDR = 5'd13;
    localparam logic [ADDR_W-1:0] EPC_ADDR   = 5'd14;

    // Field positions. IM and IP occupy the same bits in SR and Cause.
    localparam int unsigned IM_LO  = 10;
    localparam int unsigned IM_HI  = 15;
    localparam int unsigned IP_LO  = 10;
    localparam int unsigned IP_HI  = 15;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned IE_BIT  = 0;
    localparam int unsigned BD_BIT  = 31;
    localparam int unsigned EXC_LO  = 2;
    localparam int unsigned EXC_HI  = 6;

    typedef enum logic [EXC_W-1:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_req_gen.sv
// cp0_req_gen: combinational exception/interrupt request generation.
// Ports:
//   im          interrupt mask (SR.IM)
//   exl, ie     SR.EXL and SR.IE
//   hw_int      external interrupt lines
//   exc_code_in M-stage exception code, 0 = none
//   int_req_c   interrupt request
//   exc_req_c   synchronous exception request
//   req_c       take exception/interrupt this cycle
//   exc_code_c  code to record; an interrupt has priority and records Int
module cp0_req_gen
    import cp0_defs::*;
(
    input  logic [INT_W-1:0] im,
    input  logic             exl,
    input  logic             ie,
    input  logic [INT_W-1:0] hw_int,
    input  logic [EXC_W-1:0] exc_code_in,
    output logic             int_req_c,
    output logic             exc_req_c,
    output logic             req_c,
    output logic [EXC_W-1:0] exc_code_c
);

    assign int_req_c  = ie & ~exl & (|(hw_int & im));
    assign exc_req_c  = (exc_code_in != '0) & ~exl;
    assign req_c      = int_req_c | exc_req_c;
    assign exc_code_c = int_req_c ? EXC_W'(EXC_INT) : exc_code_in;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 at the M stage; holds SR, Cause and EPC.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   En, CP0Add   mtc0 write enable and CP0 register number (also mfc0 address)
//   CP0In        mtc0 write data
//   CP0Out       mfc0 read data (combinational, pre-edge state)
//   VPC, BDIn    PC of the M-stage instruction and its delay-slot flag
//   ExcCodeIn    M-stage exception code, 0 = none
//   HWInt        level-sensitive external interrupt lines
//   EXLClr       eret in M stage
//   Req          take exception/interrupt this cycle (combinational)
//   EPCOut       current EPC register
module cp0_unit
    import cp0_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              En,
    input  logic [ADDR_W-1:0] CP0Add,
    input  logic [DATA_W-1:0] CP0In,
    output logic [DATA_W-1:0] CP0Out,
    input  logic [DATA_W-1:0] VPC,
    input  logic              BDIn,
    input  logic [EXC_W-1:0]  ExcCodeIn,
    input  logic [INT_W-1:0]  HWInt,
    input  logic              EXLClr,
    output logic              Req,
    output logic [DATA_W-1:0] EPCOut
);

    logic [INT_W-1:0]  im;
    logic              exl;
    logic              ie;
    logic              bd;
    logic [INT_W-1:0]  ip;
    logic [EXC_W-1:0]  exc_code;
    logic [DATA_W-1:0] epc;

    logic              int_req_c;
    logic              exc_req_c;
    logic [EXC_W-1:0]  exc_code_sel_c;
    logic [DATA_W-1:0] epc_victim_c;

    // Only the architected SR bits are writable; the rest are dropped.
    logic unused_cp0in_bits;
    assign unused_cp0in_bits = ^{CP0In[31:16], CP0In[9:2]};

    cp0_req_gen u_req_gen (
        .im          (im),
        .exl         (exl),
        .ie          (ie),
        .hw_int      (HWInt),
        .exc_code_in (ExcCodeIn),
        .int_req_c   (int_req_c),
        .exc_req_c   (exc_req_c),
        .req_c       (Req),
        .exc_code_c  (exc_code_sel_c)
    );

    // A delay-slot victim returns to its branch; subtraction wraps mod 2^32.
    assign epc_victim_c = BDIn ? (VPC - DATA_W'(4)) : VPC;

    // Register update: a taken request overrides any mtc0/eret in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                bd       <= BDIn;
                exc_code <= exc_code_sel_c;
                epc      <= {epc_victim_c[DATA_W-1:2], 2'b00};
            end else begin
                if (En && (CP0Add == SR_ADDR)) begin
                    im  <= CP0In[IM_HI:IM_LO];
                    exl <= CP0In[EXL_BIT];
                    ie  <= CP0In[IE_BIT];
                end
                if (En && (CP0Add == EPC_ADDR)) begin
                    epc <= {CP0In[DATA_W-1:2], 2'b00};
                end
                // Placed after the SR write so eret wins over mtc0 SR on EXL.
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read views; unimplemented bits and addresses read zero.
    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            SR_ADDR: begin
                CP0Out[IM_HI:IM_LO] = im;
                CP0Out[EXL_BIT]     = exl;
                CP0Out[IE_BIT]      = ie;
            end
            CAUSE_ADDR: begin
                CP0Out[BD_BIT]        = bd;
                CP0Out[IP_HI:IP_LO]   = ip;
                CP0Out[EXC_HI:EXC_LO] = exc_code;
            end
            EPC_ADDR: CP0Out = epc;
            default:  CP0Out = '0;
        endcase
    end

    assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed test-plan sequence followed by randomized stimulus,
// checked every cycle against an architectural model of SR/Cause/EPC words.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        En;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;

    int checks = 0;
    int errors = 0;

    // Model state: architectural register words as software sees them.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .En        (En),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .Req       (Req),
        .EPCOut    (EPCOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_int_req();
        return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic model_req();
        return model_int_req() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one clock edge's worth of architectural effects.
    task automatic model_edge();
        logic        take;
        logic        intr;
        logic [31:0] ret;
        if (reset) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else begin
            take = model_req();
            intr = model_int_req();
            m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
            if (take) begin
                m_sr    = m_sr | 32'h2;
                ret     = BDIn ? VPC - 32'd4 : VPC;
                m_epc   = ret & ~32'h3;
                m_cause = (m_cause & 32'h0000_FC00)
                        | (BDIn ? 32'h8000_0000 : 32'h0)
                        | (32'(intr ? 5'd0 : ExcCodeIn) << 2);
            end else begin
                if (En && CP0Add == 5'd12) m_sr  = CP0In & 32'h0000_FC03;
                if (En && CP0Add == 5'd14) m_epc = CP0In & ~32'h3;
                if (EXLClr)                m_sr  = m_sr & ~32'h2;
            end
        end
    endtask

    task automatic idle();
        reset = 1'b0; En = 1'b0; CP0Add = 5'd0; CP0In = 32'd0;
        VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    // Compare all outputs with the model, then clock once.
    task automatic tick();
        #2;
        check("req",    32'(Req), 32'(model_req()));
        check("cp0out", CP0Out,   model_read(CP0Add));
        check("epcout", EPCOut,   m_epc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Read a register with fixed expectation without clocking.
    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        CP0Add = a;
        #1;
        check(tag, CP0Out, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); En = 1'b1; CP0Add = a; CP0In = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        #1;
        reset = 1'b0;

        // 1: post-reset reads, interrupts masked by IE=0
        HWInt = 6'b111111;
        peek("rst_sr", 5'd12, 32'd0);
        peek("rst_cause", 5'd13, 32'd0);
        peek("rst_epc", 5'd14, 32'd0);
        check("rst_req", 32'(Req), 32'd0);
        tick();

        // 2: interrupt taken on HWInt[2]
        mtc0(5'd12, 32'h0000_FC01);
        HWInt = 6'b000100; VPC = 32'h0000_3010;
        #1 check("t2_req", 32'(Req), 32'd1);
        tick();
        peek("t2_epc", 5'd14, 32'h0000_3010);
        peek("t2_cause", 5'd13, 32'h0000_1000);
        peek("t2_sr", 5'd12, 32'h0000_FC03);
        tick();

        // 3: RI exception in a delay slot with IE cleared
        mtc0(5'd12, 32'h0000_FC00);
        ExcCodeIn = 5'd10; VPC = 32'h0000_3024; BDIn = 1'b1;
        #1 check("t3_req", 32'(Req), 32'd1);
        tick();
        idle();
        peek("t3_epc", 5'd14, 32'h0000_3020);
        peek("t3_cause", 5'd13, 32'h8000_0028);

        // 4: EXL blocks requests; eret re-enables them
        ExcCodeIn = 5'd12; HWInt = 6'b000001;
        #1 check("t4_req_blocked", 32'(Req), 32'd0);
        tick();
        peek("t4_ip", 5'd13, 32'h8000_0428);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        #1 check("t4_req_rise", 32'(Req), 32'd1);
        tick();
        idle();

        // 5: exception discards a same-cycle mtc0 EPC
        EXLClr = 1'b1;
        tick();
        idle();
        ExcCodeIn = 5'd4; En = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_1234; VPC = 32'h0000_4000;
        tick();
        idle();
        peek("t5_epc", 5'd14, 32'h0000_4000);
        peek("t5_cause", 5'd13, 32'h0000_0010);

        // 6: Cause is read-only; EPC low bits forced to zero
        EXLClr = 1'b1;
        tick();
        mtc0(5'd13, 32'hFFFF_FFFF);
        peek("t6_cause", 5'd13, 32'h0000_0010);
        mtc0(5'd14, 32'h0000_3007);
        #1 check("t6_epcout", EPCOut, 32'h0000_3004);

        // Wraparound: VPC = 0 in a delay slot
        ExcCodeIn = 5'd8; BDIn = 1'b1; VPC = 32'd0;
        tick();
        idle();
        #1 check("wrap_epc", EPCOut, 32'hFFFF_FFFC);
        EXLClr = 1'b1;
        tick();

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            int sel;
            idle();
            reset  = ($urandom_range(0, 79) == 0);
            En     = ($urandom_range(0, 2) == 0);
            sel    = int'($urandom_range(0, 4));
            case (sel)
                0: CP0Add = 5'd12;
                1: CP0Add = 5'd13;
                2: CP0Add = 5'd14;
                default: CP0Add = 5'($urandom);
            endcase
            CP0In  = $urandom;
            VPC    = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            BDIn   = 1'($urandom);
            case ($urandom_range(0, 7))
                0: ExcCodeIn = 5'd4;
                1: ExcCodeIn = 5'd10;
                2: ExcCodeIn = 5'($urandom);
                3: ExcCodeIn = 5'd12;
                default: ExcCodeIn = 5'd0;
            endcase
            HWInt  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            EXLClr = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
